conv2_stream: RTL and testbench

//  Streaming 2D convolution engine; successor to conv2. Accepts a SIZE x SIZE frame row-major, one pixel/cycle,

---
 rtl/conv2_stream.sv | 223 ++++++++++++++++++++++
 tb/tb_conv2_stream.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2_stream.sv
// conv2_stream: streaming SIZE x SIZE 2D convolution, SIZEKer-square kernel, valid/ready in and out.
// Ports: clock/nreset; start/busy/done frame control; ker_we/ker_addr/ker_data coefficient writes;
// pix_valid/pix_ready/pix_data input stream; out_valid/out_ready/out_data/out_row/out_col results.
// Build macro CONV2_RELU_EN: clamp negative saturated results to zero.
module conv2_stream #(
  parameter int SIZE      = 16,
  parameter int SIZEKer   = 3,
  parameter int WIDTH_BIT = 16,
  parameter int STRIDE    = 1,
  parameter int SHIFT     = 0
) (
  input  logic                          clock,
  input  logic                          nreset,
  input  logic                          start,
  input  logic                          ker_we,
  input  logic [$clog2(SIZEKer**2)-1:0] ker_addr,
  input  logic [WIDTH_BIT-1:0]          ker_data,
  input  logic                          pix_valid,
  output logic                          pix_ready,
  input  logic [WIDTH_BIT-1:0]          pix_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH_BIT-1:0]          out_data,
  output logic [$clog2(SIZE)-1:0]       out_row,
  output logic [$clog2(SIZE)-1:0]       out_col,
  output logic                          busy,
  output logic                          done
);

  localparam int K   = SIZEKer;
  localparam int NK  = K * K;
  localparam int KA  = $clog2(NK);
  localparam int CW  = $clog2(SIZE);
  localparam int W   = WIDTH_BIT;
  localparam int ACC = 2 * W + KA;

  localparam logic signed [ACC-1:0] SAT_MAX =
    {{(ACC-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC-1:0] SAT_MIN =
    {{(ACC-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic signed [W-1:0] coef_q [NK];
  logic signed [W-1:0] coef_d [NK];
  logic signed [W-1:0] win_q  [NK];
  logic signed [W-1:0] win_d  [NK];
  logic [W-1:0]        lb_q   [K-1][SIZE];
  logic [W-1:0]        lb_d   [K-1][SIZE];

  logic [CW-1:0] prow_q, prow_d;
  logic [CW-1:0] pcol_q, pcol_d;

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [CW-1:0] out_row_q, out_row_d;
  logic [CW-1:0] out_col_q, out_col_d;

  logic pix_hs;
  logic out_hs;
  logic last_pix;
  logic win_ok;
  int   row_off;
  int   col_off;

  logic signed [ACC-1:0] acc;
  logic signed [ACC-1:0] acc_sh;
  logic [W-1:0]          res;

  assign pix_ready = (state_q == RUN) &&
                     (!out_valid_q || out_ready);
  assign pix_hs    = pix_valid && pix_ready;
  assign out_hs    = out_valid_q && out_ready;
  assign last_pix  = pix_hs &&
                     (prow_q == CW'(SIZE - 1)) &&
                     (pcol_q == CW'(SIZE - 1));

  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_pix) state_d = DRAIN;
      // Leave as the last result is being taken so done
      // lands in the cycle right after that handshake.
      DRAIN:   if (!out_valid_q || out_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    coef_d = coef_q;
    if (state_q == IDLE && ker_we && int'(ker_addr) < NK)
      coef_d[ker_addr] = ker_data;
  end

  always_comb begin
    prow_d = prow_q;
    pcol_d = pcol_q;
    if (state_q == IDLE && start) begin
      prow_d = '0;
      pcol_d = '0;
    end else if (pix_hs) begin
      if (pcol_q == CW'(SIZE - 1)) begin
        pcol_d = '0;
        prow_d = last_pix ? '0 : prow_q + CW'(1);
      end else begin
        pcol_d = pcol_q + CW'(1);
      end
    end
  end

  // Window shifts left one column per pixel; the new right
  // column is the line-buffer column plus the live pixel.
  // lb[0] holds the previous row, lb[k] the row k+1 above.
  always_comb begin
    win_d = win_q;
    lb_d  = lb_q;
    if (pix_hs) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_d[r*K+c] = win_q[r*K+c+1];
        end
      end
      for (int r = 0; r < K - 1; r++) begin
        win_d[r*K+K-1] = lb_q[K-2-r][pcol_q];
      end
      win_d[NK-1] = pix_data;
      lb_d[0][pcol_q] = pix_data;
      for (int k = 1; k < K - 1; k++) begin
        lb_d[k][pcol_q] = lb_q[k-1][pcol_q];
      end
    end
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < NK; i++) begin
      acc = acc + ACC'(coef_q[i]) * ACC'(win_d[i]);
    end
    acc_sh = acc >>> SHIFT;
    if (acc_sh > SAT_MAX)
      res = SAT_MAX[W-1:0];
    else if (acc_sh < SAT_MIN)
      res = SAT_MIN[W-1:0];
    else
      res = acc_sh[W-1:0];
`ifdef CONV2_RELU_EN
    if (res[W-1])
      res = '0;
`endif
  end

  always_comb begin
    row_off = int'(prow_q) - (K - 1);
    col_off = int'(pcol_q) - (K - 1);
    win_ok  = (row_off >= 0) && (col_off >= 0) &&
              ((row_off % STRIDE) == 0) &&
              ((col_off % STRIDE) == 0);
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    if (pix_hs && win_ok) begin
      out_valid_d = 1'b1;
      out_data_d  = res;
      out_row_d   = CW'(row_off / STRIDE);
      out_col_d   = CW'(col_off / STRIDE);
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      prow_q      <= '0;
      pcol_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      for (int i = 0; i < NK; i++) begin
        coef_q[i] <= '0;
        win_q[i]  <= '0;
      end
      for (int k = 0; k < K - 1; k++) begin
        for (int c = 0; c < SIZE; c++) begin
          lb_q[k][c] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      prow_q      <= prow_d;
      pcol_q      <= pcol_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      coef_q      <= coef_d;
      win_q       <= win_d;
      lb_q        <= lb_d;
    end
  end

endmodule

// File: tb/tb_conv2_stream.sv
// tb_conv2_stream: randomized self-checking bench for conv2_stream.
// Three instances: 4x4/stride1, 5x5/stride2, 4x4/shift2.
`timescale 1ns/1ps
module tb_conv2_stream;

  typedef struct {
    logic [15:0] d;
    logic [2:0]  r;
    logic [2:0]  c;
  } res_t;

  logic        clock = 1'b0;
  logic        nreset = 1'b0;
  logic        start = 1'b0;
  logic        ker_we = 1'b0;
  logic        all_k = 1'b0;
  logic [3:0]  ker_addr = '0;
  logic [15:0] ker_data = '0;
  logic        pix_valid = 1'b0;
  logic [15:0] pix_data = '0;
  logic        out_ready = 1'b0;
  logic [1:0]  sel = '0;

  logic [2:0]  st, kw, pr, ov, bs, dn;
  logic [15:0] od0, od1, od2;
  logic [1:0]  r0, c0, r2, c2;
  logic [2:0]  r1, c1;

  logic        o_pr, o_ov, o_bs, o_dn;
  logic [15:0] o_d;
  logic [2:0]  o_r, o_c;

  int   n_chk = 0;
  int   n_fail = 0;
  int   ker_m [9];
  int   img [25];
  res_t exp_q [$];

  always #5 clock = ~clock;

  always_comb begin
    st = '0;
    kw = '0;
    if (start) st[sel] = 1'b1;
    if (ker_we) begin
      if (all_k) kw = '1;
      else kw[sel] = 1'b1;
    end
  end

  always_comb begin
    o_pr = pr[sel];
    o_ov = ov[sel];
    o_bs = bs[sel];
    o_dn = dn[sel];
    case (sel)
      2'd1:    begin o_d = od1; o_r = r1; o_c = c1; end
      2'd2:    begin o_d = od2; o_r = {1'b0, r2}; o_c = {1'b0, c2}; end
      default: begin o_d = od0; o_r = {1'b0, r0}; o_c = {1'b0, c0}; end
    endcase
  end

  conv2_stream #(.SIZE(4), .SIZEKer(3), .WIDTH_BIT(16), .STRIDE(1), .SHIFT(0)) u_dut0 (
    .clock(clock), .nreset(nreset), .start(st[0]), .ker_we(kw[0]),
    .ker_addr(ker_addr), .ker_data(ker_data), .pix_valid(pix_valid),
    .pix_ready(pr[0]), .pix_data(pix_data), .out_valid(ov[0]),
    .out_ready(out_ready), .out_data(od0), .out_row(r0), .out_col(c0),
    .busy(bs[0]), .done(dn[0]));

  conv2_stream #(.SIZE(5), .SIZEKer(3), .WIDTH_BIT(16), .STRIDE(2), .SHIFT(0)) u_dut1 (
    .clock(clock), .nreset(nreset), .start(st[1]), .ker_we(kw[1]),
    .ker_addr(ker_addr), .ker_data(ker_data), .pix_valid(pix_valid),
    .pix_ready(pr[1]), .pix_data(pix_data), .out_valid(ov[1]),
    .out_ready(out_ready), .out_data(od1), .out_row(r1), .out_col(c1),
    .busy(bs[1]), .done(dn[1]));

  conv2_stream #(.SIZE(4), .SIZEKer(3), .WIDTH_BIT(16), .STRIDE(1), .SHIFT(2)) u_dut2 (
    .clock(clock), .nreset(nreset), .start(st[2]), .ker_we(kw[2]),
    .ker_addr(ker_addr), .ker_data(ker_data), .pix_valid(pix_valid),
    .pix_ready(pr[2]), .pix_data(pix_data), .out_valid(ov[2]),
    .out_ready(out_ready), .out_data(od2), .out_row(r2), .out_col(c2),
    .busy(bs[2]), .done(dn[2]));

  function automatic int p_size(input int s);
    return (s == 1) ? 5 : 4;
  endfunction

  function automatic int p_stride(input int s);
    return (s == 1) ? 2 : 1;
  endfunction

  function automatic int p_shift(input int s);
    return (s == 2) ? 2 : 0;
  endfunction

  function automatic int rnd16(input bit full);
    logic [15:0] v;
    v = 16'($urandom);
    if (full) return int'($signed(v));
    return int'($urandom_range(16)) - 8;
  endfunction

  task automatic build_expected(input int s);
    int sz, sd, sh, no;
    longint acc;
    res_t e;
    sz = p_size(s);
    sd = p_stride(s);
    sh = p_shift(s);
    no = (sz - 3) / sd + 1;
    exp_q.delete();
    for (int orw = 0; orw < no; orw++) begin
      for (int ocl = 0; ocl < no; ocl++) begin
        acc = 0;
        for (int r = 0; r < 3; r++) begin
          for (int c = 0; c < 3; c++) begin
            acc += longint'(ker_m[r*3+c]) *
                   longint'(img[(orw*sd+r)*sz + ocl*sd + c]);
          end
        end
        acc = acc >>> sh;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
`ifdef CONV2_RELU_EN
        if (acc < 0) acc = 0;
`endif
        e.d = 16'(acc);
        e.r = 3'(orw);
        e.c = 3'(ocl);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic write_kernel();
    all_k = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      ker_we = 1'b1;
      ker_addr = 4'(i);
      ker_data = 16'(ker_m[i]);
    end
    @(negedge clock);
    ker_we = 1'b0;
    all_k = 1'b0;
  endtask

  task automatic run_frame(input int s, input int pv, input int orp,
                           input int hold0, input bit noise,
                           input string tag);
    int n, pidx, cyc, last_o, ndone, held;
    bit stall;
    logic [15:0] pd;
    logic [2:0] prr, pcc;
    res_t e;
    build_expected(s);
    n = p_size(s) * p_size(s);
    sel = 2'(s);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    pidx = 0; cyc = 0; last_o = -100; ndone = 0; held = 0;
    stall = 1'b0; pd = '0; prr = '0; pcc = '0;
    while (cyc < 4000 && !(ndone > 0 && cyc > last_o + 4)) begin
      pix_valid = (pidx < n) && ($urandom_range(99) < pv);
      pix_data = (pidx < n) ? 16'(img[pidx]) : 16'h0;
      if (o_ov && held < hold0) begin
        out_ready = 1'b0;
        held++;
      end else begin
        out_ready = ($urandom_range(99) < orp);
      end
      ker_we = noise && ndone == 0 && ($urandom_range(1) == 1);
      ker_addr = 4'($urandom);
      ker_data = 16'($urandom);
      start = noise && ndone == 0 && ($urandom_range(3) == 0);
      #1;
      if (stall) begin
        n_chk++;
        if (o_ov !== 1'b1 || o_d !== pd || o_r !== prr || o_c !== pcc) begin
          n_fail++;
          $display("FAIL %s hold: got v=%b d=%h r=%0d c=%0d need v=1 d=%h r=%0d c=%0d",
                   tag, o_ov, o_d, o_r, o_c, pd, prr, pcc);
        end
      end
      if (o_ov && !out_ready) begin
        n_chk++;
        if (o_pr !== 1'b0) begin
          n_fail++;
          $display("FAIL %s pix_ready_stall: got %b need 0", tag, o_pr);
        end
      end
      if (o_dn === 1'b1) begin
        ndone++;
        n_chk++;
        if (ndone != 1 || cyc != last_o + 1 || exp_q.size() != 0 || pidx != n) begin
          n_fail++;
          $display("FAIL %s done: got #%0d at cyc %0d left %0d pix %0d need #1 at cyc %0d left 0 pix %0d",
                   tag, ndone, cyc, exp_q.size(), pidx, last_o + 1, n);
        end
      end
      if (o_ov && out_ready) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s extra_out: got d=%h r=%0d c=%0d need none", tag, o_d, o_r, o_c);
        end else begin
          e = exp_q.pop_front();
          if (o_d !== e.d || o_r !== e.r || o_c !== e.c) begin
            n_fail++;
            $display("FAIL %s out: got d=%h r=%0d c=%0d need d=%h r=%0d c=%0d",
                     tag, o_d, o_r, o_c, e.d, e.r, e.c);
          end
        end
        last_o = cyc;
      end
      if (pix_valid && o_pr) pidx++;
      stall = o_ov && !out_ready;
      pd = o_d; prr = o_r; pcc = o_c;
      cyc++;
      @(negedge clock);
    end
    pix_valid = 1'b0;
    ker_we = 1'b0;
    start = 1'b0;
    #1;
    n_chk++;
    if (ndone != 1 || exp_q.size() != 0 || pidx != n || o_bs !== 1'b0) begin
      n_fail++;
      $display("FAIL %s end: got done=%0d left=%0d pix=%0d busy=%b need 1/0/%0d/0",
               tag, ndone, exp_q.size(), pidx, o_bs, n);
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      n_chk++;
      if ({o_pr, o_ov, o_bs, o_dn} !== 4'b0 || o_d !== 16'h0 ||
          o_r !== 3'd0 || o_c !== 3'd0) begin
        n_fail++;
        $display("FAIL reset%0d: got pr=%b ov=%b bs=%b dn=%b d=%h r=%0d c=%0d need all 0",
                 s, o_pr, o_ov, o_bs, o_dn, o_d, o_r, o_c);
      end
    end
    @(negedge clock);
    nreset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_identity();
    for (int i = 0; i < 9; i++) ker_m[i] = (i == 4) ? 1 : 0;
    for (int i = 0; i < 25; i++) img[i] = i;
    write_kernel();
    run_frame(0, 100, 100, 0, 1'b0, "identity");
  endtask

  task automatic test_ones_shift();
    for (int i = 0; i < 9; i++) ker_m[i] = 1;
    for (int i = 0; i < 25; i++) img[i] = 1;
    write_kernel();
    run_frame(0, 100, 100, 0, 1'b0, "ones");
    run_frame(2, 100, 100, 0, 1'b0, "ones_shift2");
  endtask

  task automatic test_stride();
    for (int i = 0; i < 25; i++) img[i] = i;
    run_frame(1, 100, 100, 0, 1'b0, "stride2");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 25; i++) img[i] = 32767;
    run_frame(0, 100, 100, 0, 1'b0, "sat_pos");
    for (int i = 0; i < 25; i++) img[i] = -32768;
    run_frame(0, 100, 100, 0, 1'b0, "sat_neg");
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 9; i++) ker_m[i] = (i == 4) ? 1 : 0;
    for (int i = 0; i < 25; i++) img[i] = i;
    write_kernel();
    run_frame(0, 100, 100, 5, 1'b0, "hold5");
    run_frame(1, 100, 40, 3, 1'b0, "hold_rand");
  endtask

  task automatic test_ignored_ctrl();
    for (int i = 0; i < 9; i++) ker_m[i] = rnd16(1'b0);
    write_kernel();
    all_k = 1'b1;
    for (int a = 9; a < 16; a++) begin
      @(negedge clock);
      ker_we = 1'b1;
      ker_addr = 4'(a);
      ker_data = 16'($urandom);
    end
    @(negedge clock);
    ker_we = 1'b0;
    all_k = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 25; i++) img[i] = rnd16(1'b0);
      run_frame(f % 2, 80, 80, 0, 1'b1, "noise");
    end
    run_frame(0, 100, 100, 0, 1'b0, "after_noise");
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 9; i++) ker_m[i] = rnd16(f[0]);
      for (int i = 0; i < 25; i++) img[i] = rnd16(f[0]);
      write_kernel();
      run_frame(f % 3, 60 + f * 8, 50 + f * 10, 0, 1'b0, "random");
    end
  endtask

  task automatic test_abort();
    sel = 2'd0;
    for (int i = 0; i < 9; i++) ker_m[i] = rnd16(1'b0) + 20;
    write_kernel();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      pix_valid = 1'b1;
      pix_data = 16'(i + 3);
      out_ready = 1'b1;
      ker_we = (i == 3);
      ker_addr = 4'd4;
      ker_data = 16'd99;
      start = (i == 5);
      @(negedge clock);
    end
    pix_valid = 1'b0;
    ker_we = 1'b0;
    start = 1'b0;
    #1;
    n_chk++;
    if (o_bs !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_busy: got %b need 1", o_bs);
    end
    nreset = 1'b0;
    #1;
    n_chk++;
    if ({o_pr, o_ov, o_bs, o_dn} !== 4'b0 || o_d !== 16'h0 ||
        o_r !== 3'd0 || o_c !== 3'd0) begin
      n_fail++;
      $display("FAIL abort_reset: got pr=%b ov=%b bs=%b dn=%b d=%h need all 0",
               o_pr, o_ov, o_bs, o_dn, o_d);
    end
    @(negedge clock);
    @(negedge clock);
    nreset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      #1;
      n_chk++;
      if (o_dn !== 1'b0 || o_bs !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_idle: got done=%b busy=%b need 0/0", o_dn, o_bs);
      end
    end
    for (int i = 0; i < 9; i++) ker_m[i] = 0;
    for (int i = 0; i < 25; i++) img[i] = rnd16(1'b1);
    run_frame(0, 100, 100, 0, 1'b0, "zero_kernel");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout need end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_identity();
    test_ones_shift();
    test_stride();
    test_saturation();
    test_backpressure();
    test_ignored_ctrl();
    test_back_to_back();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
